tt_um_fifo: RTL and testbench
=============================

TT_UM_FIFO -- requirements
Module: tt_um_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of FIFO entries; power of two, minimum 4.
REQ-002 Parameter WIDTH, default 8, data width in bits; fixed to 8 by the pin map.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 ena  in  1  design enable; when low, write and read requests are ignored.
REQ-006 ui_in  in  8  write data.
REQ-007 uio_in  in  8  controls:
- [0] wr_en
- [1] rd_en
- [2] clr_err, clears the sticky error flags
- [7:3] ignored
REQ-008 uo_out  out  8  read data register.
REQ-009 uio_out  out  8  status:
- [3:0] = 0
- [4] full
- [5] empty
- [6] overflow, sticky
- [7] underflow, sticky
REQ-010 uio_oe  out  8  constant 8'hF0 (bits 7:4 outputs, bits 3:0 inputs).

Function
REQ-011 Qualified requests: wr = ena & uio_in[0]; rd = ena & uio_in[1]; clr = ena & uio_in[2].
REQ-012 Write on an edge with wr & !full:
- ui_in is stored at mem[wptr].
- wptr advances by one, modulo DEPTH.
REQ-013 Read on an edge with rd & !empty:
- uo_out <= mem[rptr]; the data is visible one cycle after the request edge.
- rptr advances by one, modulo DEPTH.
REQ-014 uo_out holds its value on every edge without an accepted read; there is no fall-through.
REQ-015 count is log2(DEPTH)+1 bits wide, range 0..DEPTH:
- +1 on write only.
- -1 on read only.
- Unchanged when both or neither are accepted.
REQ-016 Flags: full = (count == DEPTH); empty = (count == 0); both are combinational from registered count.
REQ-017 Simultaneous wr & rd while full: read accepted; write also accepted; count stays DEPTH; no overflow.
REQ-018 Simultaneous wr & rd while empty: write accepted; read rejected; underflow set; uo_out unchanged.
REQ-019 wr while full without rd: data dropped; overflow set; pointers unchanged.
REQ-020 rd while empty: underflow set; nothing else changes.
REQ-021 clr clears overflow and underflow; an error raised in the same cycle wins, so the flag stays 1.
REQ-022 Pointers wrap from DEPTH-1 to 0 without loss of data or ordering.

Reset
REQ-023 Asynchronous assertion of rst_n=0 sets:
- wptr=0, rptr=0, count=0
- uo_out=8'h00
- overflow=0, underflow=0
- hence empty=1, full=0
REQ-024 Memory contents are not reset.
REQ-025 A reset mid-operation discards all stored entries.
REQ-026 The first accepted request after deassertion occurs on the first rising edge with rst_n=1.

Structure
REQ-027 Package tt_fifo_pkg holds FIFO_DEPTH=16, FIFO_WIDTH=8, and the status bit index constants.
REQ-028 One sub-module, fifo_core, contains:
- storage array and pointers
- count and flags
- read data register
REQ-029 tt_um_fifo contains only pin mapping, ena gating, the sticky error flags, and the constant uio_oe.

Verification
REQ-030 Reset, then idle: uo_out=00, uio_out=8'h20 (empty only), uio_oe=F0.
REQ-031 Write 8'hA5, 8'h3C; then read twice:
- uo_out=A5 the cycle after the first read, 3C the cycle after the second.
- empty returns to 1.
REQ-032 Write 16 values 8'h00..8'h0F: full=1 after the 16th write.
REQ-033 A 17th write 8'hFF while full: overflow=1. Reading all 16 entries then returns 00..0F in order, then empty=1.
REQ-034 Read when empty: underflow=1, uo_out unchanged. Asserting clr for one cycle then clears both sticky flags.
REQ-035 Wrap and reset:
- Write and read 40 entries, with simultaneous wr/rd at count=16 and at count=0: order is preserved, and count follows REQ-017/018.
- With ena=0 and uio_in[0]=1, no write occurs.
- Asserting rst_n mid-burst returns the block to the REQ-030 state.

Source files
------------

// File: rtl/tt_fifo_pkg.sv
// Shared constants for the Tiny Tapeout FIFO: geometry, control/status bit
// positions on the bidirectional pins, and the status byte packing helper.
package tt_fifo_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_WIDTH = 8;

  localparam int CTL_WR  = 0;
  localparam int CTL_RD  = 1;
  localparam int CTL_CLR = 2;

  localparam int ST_FULL  = 4;
  localparam int ST_EMPTY = 5;
  localparam int ST_OVF   = 6;
  localparam int ST_UDF   = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  // Status byte seen on uio_out; the low nibble is the input half of the pins.
  function automatic logic [7:0] pack_status(input logic full,
                                             input logic empty,
                                             input logic ovf,
                                             input logic udf);
    logic [7:0] s;
    s           = 8'h00;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_OVF]   = ovf;
    s[ST_UDF]   = udf;
    return s;
  endfunction

endpackage

// File: rtl/fifo_core.sv
// Synchronous FIFO storage: memory array, read/write pointers, occupancy
// count with derived full/empty, and a registered (non fall-through) read port.
module fifo_core
  import tt_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             wr_acc;
  logic             rd_acc;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A write into a full FIFO is still taken when a read frees the slot on
  // the same edge; the read samples the old entry before it is overwritten.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_fifo.sv
// Tiny Tapeout wrapper around fifo_core: pin mapping, ena gating of requests,
// sticky overflow/underflow flags with clear, and the fixed pin directions.
module tt_um_fifo
  import tt_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [7:0]       uio_in,
  output logic [WIDTH-1:0] uo_out,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe
);

  logic wr;
  logic rd;
  logic clr;
  logic full;
  logic empty;
  logic ovf;
  logic udf;
  logic ovf_evt;
  logic udf_evt;
  logic unused_ctl;

  assign wr  = ena & uio_in[CTL_WR];
  assign rd  = ena & uio_in[CTL_RD];
  assign clr = ena & uio_in[CTL_CLR];

  assign unused_ctl = &{1'b0, uio_in[7:3]};

  fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr),
    .rd    (rd),
    .din   (ui_in),
    .dout  (uo_out),
    .full  (full),
    .empty (empty)
  );

  // A concurrent read makes room, so a write into a full FIFO is only an
  // overflow when no read accompanies it.
  assign ovf_evt = wr & full & ~rd;
  assign udf_evt = rd & empty;

  // New errors take priority over clr so an event in the clearing cycle sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_evt) begin
        ovf <= 1'b1;
      end else if (clr) begin
        ovf <= 1'b0;
      end
      if (udf_evt) begin
        udf <= 1'b1;
      end else if (clr) begin
        udf <= 1'b0;
      end
    end
  end

  assign uio_out = pack_status(full, empty, ovf, udf);
  assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_fifo.sv
// Directed bench for tt_um_fifo: reset state, ordering, full/empty corners,
// sticky errors with clear, pointer wrap, ena gating and mid-burst reset.
module tb_tt_um_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_pass = 0;
  int n_total = 0;

  tt_um_fifo dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock edge, then settle before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Status bytes: empty=20, full=10, +ovf=40, +udf=80.
  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) cyc();
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_st", uio_out, 8'h20);
    chk("rst_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    cyc();
    chk("idle_uo", uo_out, 8'h00);
    chk("idle_st", uio_out, 8'h20);

    // Two writes, two reads
    ui_in = 8'hA5; uio_in = 8'h01; cyc();
    ui_in = 8'h3C; cyc();
    chk("two_wr_st", uio_out, 8'h00);
    uio_in = 8'h02; cyc();
    chk("rd1", uo_out, 8'hA5);
    cyc();
    chk("rd2", uo_out, 8'h3C);
    chk("rd2_st", uio_out, 8'h20);
    uio_in = 8'h00; cyc();
    chk("hold", uo_out, 8'h3C);

    // Fill to full
    uio_in = 8'h01;
    for (int i = 0; i < 16; i++) begin
      ui_in = 8'(i);
      cyc();
      if (i == 14) chk("fill15_st", uio_out, 8'h00);
    end
    chk("full_st", uio_out, 8'h10);

    // Overflow write is dropped
    ui_in = 8'hFF; cyc();
    chk("ovf_st", uio_out, 8'h50);
    chk("ovf_uo", uo_out, 8'h3C);

    uio_in = 8'h02;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("drain%0d", i), uo_out, 8'(i));
    end
    chk("drain_st", uio_out, 8'h60);

    // Underflow, then clear
    cyc();
    chk("udf_st", uio_out, 8'hE0);
    chk("udf_uo", uo_out, 8'h0F);
    uio_in = 8'h04; cyc();
    chk("clr_st", uio_out, 8'h20);

    // Error raised in the clearing cycle sticks
    uio_in = 8'h06; cyc();
    chk("clr_race", uio_out, 8'hA0);
    uio_in = 8'h04; cyc();
    chk("clr2_st", uio_out, 8'h20);

    // Simultaneous wr/rd while empty
    ui_in = 8'h11; uio_in = 8'h03; cyc();
    chk("wr_rd_empty_st", uio_out, 8'h80);
    chk("wr_rd_empty_uo", uo_out, 8'h0F);
    uio_in = 8'h04; cyc();
    chk("clr3_st", uio_out, 8'h00);

    // Fill across the wrap point, then simultaneous wr/rd while full
    uio_in = 8'h01;
    for (int i = 0; i < 15; i++) begin
      ui_in = 8'h20 + 8'(i);
      cyc();
    end
    chk("full2_st", uio_out, 8'h10);
    ui_in = 8'h40; uio_in = 8'h03; cyc();
    chk("wr_rd_full_uo", uo_out, 8'h11);
    chk("wr_rd_full_st", uio_out, 8'h10);
    uio_in = 8'h02;
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk($sformatf("wrap%0d", i), uo_out, 8'h20 + 8'(i));
    end
    cyc();
    chk("wrap_last", uo_out, 8'h40);
    chk("wrap_st", uio_out, 8'h20);

    for (int i = 0; i < 5; i++) begin
      ui_in = 8'h50 + 8'(i); uio_in = 8'h01; cyc();
      uio_in = 8'h02; cyc();
      chk($sformatf("pair%0d", i), uo_out, 8'h50 + 8'(i));
    end
    uio_in = 8'h00; cyc();
    chk("pair_st", uio_out, 8'h20);

    // ena low gates requests
    ena = 1'b0; ui_in = 8'h77; uio_in = 8'h01; cyc();
    chk("ena_wr_st", uio_out, 8'h20);
    uio_in = 8'h02; cyc();
    chk("ena_rd_st", uio_out, 8'h20);
    chk("ena_rd_uo", uo_out, 8'h54);
    ena = 1'b1;

    // Reset mid-burst
    uio_in = 8'h01;
    ui_in = 8'h81; cyc();
    ui_in = 8'h82; cyc();
    ui_in = 8'h83;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_uo", uo_out, 8'h00);
    chk("arst_st", uio_out, 8'h20);
    uio_in = 8'h00;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_st", uio_out, 8'h20);
    chk("post_rst_oe", uio_oe, 8'hF0);
    ui_in = 8'h99; uio_in = 8'h01; cyc();
    uio_in = 8'h02; cyc();
    chk("post_rst_rd", uo_out, 8'h99);
    chk("post_rst_empty", uio_out, 8'h20);
    uio_in = 8'h00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
